onchip_posmap_banked: RTL and testbench
=======================================

# onchip_posmap_banked

Parametrised, banked on-chip final-level PosMap for the ORAM frontend: holds one `{valid, leaf}` entry per program address in its window. It serves Read, Update, Invalidate and runtime Re-Init commands over a ready/valid interface. Update draws fresh leaves from an external PRNG handshake. Multiple banks shorten the power-up/re-init sweep. It sits beside the PLB and is the recursion terminator for the frontend lookup loop.

## Interface
- `ORAMU`, 32, program address width
- `ORAML`, 32, leaf width
- `LogEntries`, 10, log2 of entry count; `Entries = 2^LogEntries`
- `LogBanks`, 2, log2 of bank count; `LogBanks <= LogEntries`
- `AddrBase`, 0, first program address mapped by this PosMap

Ports:
- `Clock`  in  1  single clock
- `Reset`  in  1  asynchronous, active-low
- `CmdReady`  out  1  command accepted this cycle if `CmdValid`
- `CmdValid`  in  1
- `Cmd`  in  2  encoding: 00 Update, 01 Read, 10 Invalidate, 11 ReInit
- `AddrIn`  in  ORAMU  program address
- `LeafInReady`  out  1  leaf consumed this cycle if `LeafInValid`
- `LeafInValid`  in  1
- `LeafIn`  in  ORAML  random leaf from PRNG
- `OutReady`  in  1
- `OutValid`  out  1
- `OutUnInit`  out  1  entry valid bit was 0 before the op
- `OutOutOfRange`  out  1  `AddrIn` outside `[AddrBase, AddrBase+Entries)`
- `OutOldLeaf`  out  ORAML  leaf stored before the op
- `OutNewLeaf`  out  ORAML  leaf stored after the op
- `OutAddr`  out  ORAMU  echoed `AddrIn`
- `InitDone`  out  1  high once a sweep has completed and the block is not sweeping

## Operation
- Index is `AddrIn - AddrBase`, truncated to `LogEntries` bits. Bank = low `LogBanks` bits; row = remaining bits.
- States and transitions:
  - INIT: writes `{0, 0}` to row `InitCnt` of every bank in parallel. `InitCnt` runs 0 to `Entries/Banks - 1`. Next state: IDLE, or RESP if the sweep was entered by ReInit.
  - IDLE: `CmdReady=1`. On accept:
    - Out-of-range address: go to RESP with `OutOutOfRange=1`, both leaf outputs 0, `OutUnInit=0`, no RAM access.
    - ReInit: go to INIT.
    - Otherwise: go to RD (bank read issued).
  - RD: capture bank data. Update goes to WR. Invalidate writes `{0,0}` in this same cycle, then goes to RESP. Read goes to RESP.
  - WR: `LeafInReady=1`. Waits for `LeafInValid`. On transfer, writes `{1, LeafIn}`, sets `OutNewLeaf=LeafIn`, goes to RESP.
  - RESP: `OutValid=1`, outputs held stable until `OutReady`, then go to IDLE.
- Response fields:
  - Read: `OutNewLeaf = OutOldLeaf`.
  - Invalidate: `OutNewLeaf = 0`.
  - ReInit: response after the sweep, with all leaf fields 0.
- One command is outstanding at a time. `CmdReady=0` in every state except IDLE.
- Only the WR state consumes leaves. Read and Invalidate never pop the PRNG.

## Timing
- Reset (async assert): state INIT, `InitCnt=0`, all outputs 0, so `CmdReady=0`, `OutValid=0`, `LeafInReady=0`, `InitDone=0`. Sweep starts on the first edge after deassertion.
- Init sweep: `Entries/Banks` cycles; `InitDone` rises the cycle after the last row write.
- Read or Invalidate accepted at edge T: `OutValid` high from T+2.
- Update accepted at T with `LeafInValid` already high: leaf consumed at T+2, `OutValid` from T+3. Each cycle `LeafInValid` stays low adds one cycle.
- Out-of-range command: `OutValid` from T+1.
- `OutValid` with `OutReady` both high at edge E: IDLE at E, so the next accept is possible at E+1 at the earliest.
- Reset asserted mid-operation: in-flight command dropped, no response, full sweep restarts. A leaf is never consumed without its write.
- Address arithmetic is done in ORAMU bits. The range check uses an unsigned compare before truncation. `AddrBase+Entries` must not overflow ORAMU; this is checked by an elaboration assertion.

## Structure
- Shared package `posmap_pkg`: Cmd encodings (`PMUpdate`, `PMRead`, `PMInvalidate`, `PMReInit`), state enum, entry width function `ORAML+1`.
- Sub-module `posmap_bank`: single-port RAM, `ORAML+1` wide, `LogEntries-LogBanks` address bits, 1-cycle registered read, instantiated `2^LogBanks` times.
- Top: FSM, init counter, bank select mux, output registers.

## Test plan
- Reset release with `LogEntries=4`, `LogBanks=2` -> `InitDone` high exactly 5 cycles after the first active edge; then Read of addr 9 gives `OutUnInit=1`, `OutOldLeaf=0`.
- Update addr 5 with `LeafIn=0x1234` -> `OutUnInit=1`, `OutNewLeaf=0x1234`. A following Read of 5 gives `OutUnInit=0`, `OutOldLeaf=0x1234`, `OutValid` 2 cycles after accept.
- Update with `LeafInValid` held low for 4 cycles -> `OutValid` at T+7. Exactly one leaf consumed. `CmdReady` stays 0 throughout.
- `AddrBase=0x100`, Read of 0xFF and of 0x110 (`Entries=16`) -> `OutOutOfRange=1` at T+1, RAM unchanged.
- Invalidate after an Update, then ReInit -> Invalidate returns the old leaf. A subsequent Read returns `OutUnInit=1`. ReInit responds after the sweep and every entry reads invalid.
- Hold `OutReady=0` for 10 cycles, then assert reset mid-Update -> outputs stable while stalled; after reset everything is 0, the sweep reruns, and no leaf is popped.

Source files
------------

// File: rtl/posmap_pkg.sv
// Shared definitions for the banked on-chip PosMap: command encodings,
// controller states and the stored entry width ({valid, leaf}).
package posmap_pkg;

  typedef enum logic [1:0] {
    PMUpdate     = 2'b00,
    PMRead       = 2'b01,
    PMInvalidate = 2'b10,
    PMReInit     = 2'b11
  } pm_cmd_e;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_RESP
  } pm_state_e;

  function automatic int entry_width(input int oraml);
    return oraml + 1;
  endfunction

endpackage

// File: rtl/posmap_bank.sv
// Single-port PosMap bank: one {valid, leaf} word per row, write-or-read per
// cycle, read data registered one cycle after the enabled read.
module posmap_bank #(
  parameter int Width = 33,
  parameter int AddrW = 8
) (
  input  logic             Clock,
  input  logic             en_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [2**AddrW];

  // NOTE: the array has no reset; the controller's init sweep clears it, which
  // keeps it mappable onto plain RAM macros. Sequential state uses <= only.
  always_ff @(posedge Clock) begin
    if (en_i) begin
      if (we_i) mem_q[addr_i] <= wdata_i;
      else      rdata_o       <= mem_q[addr_i];
    end
  end

endmodule

// File: rtl/onchip_posmap_banked.sv
// Banked final-level PosMap: FSM, init sweep counter, bank select and
// registered response for Read/Update/Invalidate/ReInit commands.
module onchip_posmap_banked
  import posmap_pkg::*;
#(
  parameter int              ORAMU      = 32,
  parameter int              ORAML      = 32,
  parameter int              LogEntries = 10,
  parameter int              LogBanks   = 2,
  parameter logic [ORAMU-1:0] AddrBase  = '0
) (
  input  logic             Clock,
  input  logic             Reset,
  output logic             CmdReady,
  input  logic             CmdValid,
  input  logic [1:0]       Cmd,
  input  logic [ORAMU-1:0] AddrIn,
  output logic             LeafInReady,
  input  logic             LeafInValid,
  input  logic [ORAML-1:0] LeafIn,
  input  logic             OutReady,
  output logic             OutValid,
  output logic             OutUnInit,
  output logic             OutOutOfRange,
  output logic [ORAML-1:0] OutOldLeaf,
  output logic [ORAML-1:0] OutNewLeaf,
  output logic [ORAMU-1:0] OutAddr,
  output logic             InitDone
);

  localparam int EntryW  = entry_width(ORAML);
  localparam int Entries = 2**LogEntries;
  localparam int Banks   = 2**LogBanks;
  localparam int Rows    = 2**(LogEntries - LogBanks);
  localparam int RowW    = (LogEntries > LogBanks) ? LogEntries - LogBanks : 1;
  localparam int BankW   = (LogBanks > 0) ? LogBanks : 1;
  localparam logic [RowW-1:0]  LastRow   = RowW'(Rows - 1);
  localparam logic [ORAMU:0]   LimitWide = {1'b0, AddrBase} + (ORAMU+1)'(Entries);

  if (LimitWide[ORAMU]) begin : g_window_overflow
    $error("AddrBase + Entries overflows the program address width");
  end
  if (LogBanks > LogEntries) begin : g_bank_cfg
    $error("LogBanks must not exceed LogEntries");
  end

  pm_state_e        state_q;
  pm_cmd_e          cmd_q;
  logic [RowW-1:0]  init_cnt_q, row_q;
  logic [BankW-1:0] bank_q;
  logic             reinit_q, uninit_q, oor_q, init_done_q;
  logic [ORAML-1:0] old_leaf_q, new_leaf_q;
  logic [ORAMU-1:0] addr_q;

  // Below-base addresses wrap to a huge offset, so one unsigned compare covers both ends.
  logic [ORAMU-1:0]      offset;
  logic [LogEntries-1:0] idx;
  logic [RowW-1:0]       row_in;
  logic [BankW-1:0]      bank_in;
  logic                  in_range, accept;
  pm_cmd_e               cmd_in;

  assign offset   = AddrIn - AddrBase;
  assign in_range = offset < ORAMU'(Entries);
  assign idx      = offset[LogEntries-1:0];
  assign row_in   = RowW'(idx >> LogBanks);
  assign bank_in  = (LogBanks == 0) ? '0 : BankW'(idx);
  assign cmd_in   = pm_cmd_e'(Cmd);
  assign accept   = (state_q == ST_IDLE) && CmdValid;

  logic [Banks-1:0]  ram_en, ram_we;
  logic [RowW-1:0]   ram_addr;
  logic [EntryW-1:0] ram_wdata;
  logic [EntryW-1:0] ram_rdata [Banks];
  logic [EntryW-1:0] rd_entry;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    ram_en    = '0;
    ram_we    = '0;
    ram_addr  = row_q;
    ram_wdata = '0;
    unique case (state_q)
      ST_INIT: begin
        ram_en   = '1;
        ram_we   = '1;
        ram_addr = init_cnt_q;
      end
      ST_IDLE: if (accept && in_range && cmd_in != PMReInit) begin
        ram_en[bank_in] = 1'b1;
        ram_addr        = row_in;
      end
      ST_RD: if (cmd_q == PMInvalidate) begin
        ram_en[bank_q] = 1'b1;
        ram_we[bank_q] = 1'b1;
      end
      ST_WR: if (LeafInValid) begin
        ram_en[bank_q] = 1'b1;
        ram_we[bank_q] = 1'b1;
        ram_wdata      = {1'b1, LeafIn};
      end
      default: ;
    endcase
  end

  for (genvar b = 0; b < Banks; b++) begin : g_bank
    posmap_bank #(.Width(EntryW), .AddrW(RowW)) u_bank (
      .Clock   (Clock),
      .en_i    (ram_en[b]),
      .we_i    (ram_we[b]),
      .addr_i  (ram_addr),
      .wdata_i (ram_wdata),
      .rdata_o (ram_rdata[b])
    );
  end

  assign rd_entry = ram_rdata[bank_q];

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q     <= ST_INIT;
      cmd_q       <= PMUpdate;
      init_cnt_q  <= '0;
      row_q       <= '0;
      bank_q      <= '0;
      reinit_q    <= 1'b0;
      uninit_q    <= 1'b0;
      oor_q       <= 1'b0;
      init_done_q <= 1'b0;
      old_leaf_q  <= '0;
      new_leaf_q  <= '0;
      addr_q      <= '0;
    end else begin
      init_done_q <= (state_q != ST_INIT) && !(accept && in_range && cmd_in == PMReInit);
      unique case (state_q)
        ST_INIT: begin
          if (init_cnt_q == LastRow) begin
            init_cnt_q <= '0;
            state_q    <= reinit_q ? ST_RESP : ST_IDLE;
          end else begin
            init_cnt_q <= init_cnt_q + 1'b1;
          end
        end
        ST_IDLE: if (accept) begin
          addr_q     <= AddrIn;
          cmd_q      <= cmd_in;
          bank_q     <= bank_in;
          row_q      <= row_in;
          uninit_q   <= 1'b0;
          oor_q      <= !in_range;
          old_leaf_q <= '0;
          new_leaf_q <= '0;
          if (!in_range) begin
            state_q <= ST_RESP;
          end else if (cmd_in == PMReInit) begin
            reinit_q <= 1'b1;
            state_q  <= ST_INIT;
          end else begin
            state_q <= ST_RD;
          end
        end
        ST_RD: begin
          old_leaf_q <= rd_entry[ORAML-1:0];
          uninit_q   <= !rd_entry[ORAML];
          new_leaf_q <= (cmd_q == PMRead) ? rd_entry[ORAML-1:0] : '0;
          state_q    <= (cmd_q == PMUpdate) ? ST_WR : ST_RESP;
        end
        ST_WR: if (LeafInValid) begin
          new_leaf_q <= LeafIn;
          state_q    <= ST_RESP;
        end
        ST_RESP: if (OutReady) begin
          reinit_q <= 1'b0;
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

  assign CmdReady      = (state_q == ST_IDLE);
  assign LeafInReady   = (state_q == ST_WR);
  assign OutValid      = (state_q == ST_RESP);
  assign OutUnInit     = uninit_q;
  assign OutOutOfRange = oor_q;
  assign OutOldLeaf    = old_leaf_q;
  assign OutNewLeaf    = new_leaf_q;
  assign OutAddr       = addr_q;
  assign InitDone      = init_done_q;

endmodule

// File: tb/tb_onchip_posmap_banked.sv
// Directed bench for onchip_posmap_banked: 16 entries in 4 banks at base 0x100,
// covering sweep timing, all commands, leaf stalls, range edges and reset.
module tb_onchip_posmap_banked;
  import posmap_pkg::*;

  logic        Clock, Reset;
  logic        CmdReady, CmdValid;
  logic [1:0]  Cmd;
  logic [31:0] AddrIn;
  logic        LeafInReady, LeafInValid;
  logic [31:0] LeafIn;
  logic        OutReady, OutValid, OutUnInit, OutOutOfRange, InitDone;
  logic [31:0] OutOldLeaf, OutNewLeaf, OutAddr;

  int n_checks = 0;
  int n_fail   = 0;
  int pops     = 0;

  onchip_posmap_banked #(
    .ORAMU(32), .ORAML(32), .LogEntries(4), .LogBanks(2), .AddrBase(32'h100)
  ) dut (
    .Clock(Clock), .Reset(Reset),
    .CmdReady(CmdReady), .CmdValid(CmdValid), .Cmd(Cmd), .AddrIn(AddrIn),
    .LeafInReady(LeafInReady), .LeafInValid(LeafInValid), .LeafIn(LeafIn),
    .OutReady(OutReady), .OutValid(OutValid), .OutUnInit(OutUnInit),
    .OutOutOfRange(OutOutOfRange), .OutOldLeaf(OutOldLeaf), .OutNewLeaf(OutNewLeaf),
    .OutAddr(OutAddr), .InitDone(InitDone)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Leaves popped from the PRNG side, seen at the transfer edge.
  always @(posedge Clock) if (LeafInReady && LeafInValid) pops++;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (OutValid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic accept_cmd(input string tag, input logic [1:0] cmd, input logic [31:0] addr);
    check({tag, "_cmdready"}, CmdReady, 1);
    Cmd = cmd; AddrIn = addr; CmdValid = 1'b1;
    tick();
    CmdValid = 1'b0;
  endtask

  task automatic check_resp(input string tag, input logic oor, input logic uninit,
                            input logic [31:0] old_leaf, input logic [31:0] new_leaf,
                            input logic [31:0] addr);
    check({tag, "_resp"}, {OutValid, OutOutOfRange, OutUnInit, OutOldLeaf, OutNewLeaf, OutAddr},
          {1'b1, oor, uninit, old_leaf, new_leaf, addr});
  endtask

  task automatic drain();
    OutReady = 1'b1;
    tick();
    OutReady = 1'b0;
  endtask

  task automatic do_cmd(input string tag, input logic [1:0] cmd, input logic [31:0] addr,
                        input int exp_lat, input logic oor, input logic uninit,
                        input logic [31:0] old_leaf, input logic [31:0] new_leaf);
    int lat;
    accept_cmd(tag, cmd, addr);
    wait_out(lat);
    check({tag, "_latency"}, lat, exp_lat);
    check_resp(tag, oor, uninit, old_leaf, new_leaf, addr);
    drain();
  endtask

  task automatic wait_init(input string tag);
    int n;
    n = 0;
    while (InitDone !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    // Four rows per bank: rows written on edges 1..4, InitDone visible after edge 5.
    check({tag, "_initdone_edges"}, n, 5);
    check({tag, "_cmdready"}, CmdReady, 1);
  endtask

  initial begin
    int  lat;
    logic ok;
    Reset = 1'b0; CmdValid = 1'b0; Cmd = 2'b00; AddrIn = '0;
    LeafInValid = 1'b0; LeafIn = '0; OutReady = 1'b0;

    tick(); tick();
    check("reset_outputs",
          {CmdReady, OutValid, LeafInReady, InitDone, OutUnInit, OutOutOfRange,
           OutOldLeaf, OutNewLeaf, OutAddr}, '0);
    Reset = 1'b1;
    wait_init("powerup");

    // Reads must never pop the PRNG, so keep a leaf on offer.
    LeafInValid = 1'b1; LeafIn = 32'hDEAD_BEEF;
    do_cmd("read9_fresh", PMRead, 32'h109, 1, 1'b0, 1'b1, 32'h0, 32'h0);
    check("pops_after_read", pops, 0);

    LeafIn = 32'h1234;
    do_cmd("update5", PMUpdate, 32'h105, 2, 1'b0, 1'b1, 32'h0, 32'h1234);
    check("pops_after_update", pops, 1);
    LeafIn = 32'hDEAD_BEEF;
    do_cmd("read5", PMRead, 32'h105, 1, 1'b0, 1'b0, 32'h1234, 32'h1234);
    check("pops_after_read5", pops, 1);

    // Update with the leaf withheld for four WR cycles.
    LeafInValid = 1'b0;
    accept_cmd("update10_stall", PMUpdate, 32'h10A);
    tick();
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (LeafInReady !== 1'b1 || CmdReady !== 1'b0 || OutValid !== 1'b0) ok = 1'b0;
      tick();
    end
    check("stall_wr_handshake", ok, 1);
    check("stall_no_early_valid", {OutValid, LeafInReady}, 2'b01);
    LeafIn = 32'hABCD; LeafInValid = 1'b1;
    tick();
    check_resp("update10_stall", 1'b0, 1'b1, 32'h0, 32'hABCD, 32'h10A);
    check("stall_pops", pops, 2);
    LeafIn = 32'hDEAD_BEEF;
    drain();

    do_cmd("oor_below", PMRead, 32'h0FF, 0, 1'b1, 1'b0, 32'h0, 32'h0);
    do_cmd("oor_limit", PMRead, 32'h110, 0, 1'b1, 1'b0, 32'h0, 32'h0);
    do_cmd("oor_inv_alias", PMInvalidate, 32'h11A, 0, 1'b1, 1'b0, 32'h0, 32'h0);
    do_cmd("oor_upd_below", PMUpdate, 32'h0FA, 0, 1'b1, 1'b0, 32'h0, 32'h0);
    check("oor_no_pops", pops, 2);
    do_cmd("read10_kept", PMRead, 32'h10A, 1, 1'b0, 1'b0, 32'hABCD, 32'hABCD);

    do_cmd("inval5", PMInvalidate, 32'h105, 1, 1'b0, 1'b0, 32'h1234, 32'h0);
    do_cmd("read5_invalid", PMRead, 32'h105, 1, 1'b0, 1'b1, 32'h0, 32'h0);
    check("inval_no_pops", pops, 2);

    LeafIn = 32'hF00D;
    do_cmd("update15", PMUpdate, 32'h10F, 2, 1'b0, 1'b1, 32'h0, 32'hF00D);
    LeafIn = 32'hDEAD_BEEF;

    accept_cmd("reinit", PMReInit, 32'h100);
    check("reinit_initdone_low", InitDone, 0);
    wait_out(lat);
    check("reinit_latency", lat, 4);
    check_resp("reinit", 1'b0, 1'b0, 32'h0, 32'h0, 32'h100);
    drain();
    check("reinit_initdone_high", InitDone, 1);
    for (int i = 0; i < 16; i++)
      do_cmd($sformatf("reinit_entry%0d", i), PMRead, 32'h100 + i, 1, 1'b0, 1'b1, 32'h0, 32'h0);
    check("reinit_pops", pops, 3);

    // Response held while the consumer stalls.
    LeafIn = 32'h5555;
    accept_cmd("update7", PMUpdate, 32'h107);
    wait_out(lat);
    check("update7_latency", lat, 2);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if ({OutValid, OutOutOfRange, OutUnInit, OutOldLeaf, OutNewLeaf, OutAddr} !==
          {1'b1, 1'b0, 1'b1, 32'h0, 32'h5555, 32'h107}) ok = 1'b0;
      tick();
    end
    check("stall_outputs_stable", ok, 1);
    check("stall_update_pops", pops, 4);
    drain();

    // Reset in the middle of an Update waiting for its leaf.
    LeafInValid = 1'b0;
    accept_cmd("update3_reset", PMUpdate, 32'h103);
    tick();
    check("update3_in_wr", LeafInReady, 1);
    #2 Reset = 1'b0;
    #1;
    check("midreset_outputs",
          {CmdReady, OutValid, LeafInReady, InitDone, OutUnInit, OutOutOfRange,
           OutOldLeaf, OutNewLeaf, OutAddr}, '0);
    LeafInValid = 1'b1; LeafIn = 32'h9999;
    tick(); tick();
    Reset = 1'b1;
    wait_init("after_reset");
    check("reset_no_pops", pops, 4);
    do_cmd("read7_swept", PMRead, 32'h107, 1, 1'b0, 1'b1, 32'h0, 32'h0);
    do_cmd("read3_swept", PMRead, 32'h103, 1, 1'b0, 1'b1, 32'h0, 32'h0);
    check("final_pops", pops, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
